uart_rx_pair: RTL
=================

// Module: uart_rx_pair
// PURPOSE
//  UART receiver: 8N1 serial in, 16x oversampled, two-entry byte holding buffer.
//  Sits upstream of the memory-mapped peripheral and drives its rx_data1, rx_data2 and rec[1:0] inputs.
//  The CPU reads both bytes, then pulses clr to free the buffer.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock, Hz
//  BAUD        9600         line rate, bit/s
//  OVERSAMPLE  16           ticks per bit, fixed; other values unsupported
//  DIV         CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation (651 at defaults); localparam
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  rx          in   1  asynchronous serial line, idle high
//  clr         in   1  one-cycle pulse: empties buffer (rec<=2'b00)
//  rx_data1    out  8  first buffered byte
//  rx_data2    out  8  second buffered byte
//  rec         out  2  buffer state: 00 empty, 01 one byte, 11 two bytes
//  frame_err   out  1  one-cycle pulse: stop bit sampled low
//  overrun     out  1  one-cycle pulse: byte completed while rec==11
//  parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 without UART_PARITY_EN
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, counters 0, rx_data1=rx_data2=0, rec=00, all pulses 0, sync FFs=1.
//    Reset mid-frame aborts the frame; no partial byte is stored.
//  - rx passes 2-FF synchronizer (rx_s); 2-cycle input latency.
//  - Tick gen: free-running div_cnt 0..DIV-1; tick=1 for one clk when div_cnt==DIV-1.
//  - FSM (advances only on tick cycles except where noted); scnt 4b, bcnt 3b, shift 8b:
//    IDLE : rx_s==0 -> START, scnt=0.
//    START: scnt++; at scnt==7: rx_s==0 -> DATA (scnt=0, bcnt=0); else glitch -> IDLE.
//    DATA : scnt++; at scnt==15: shift={rx_s,shift[7:1]} (LSB first), scnt=0;
//           bcnt==7 -> STOP (or PARITY with macro), else bcnt++.
//    STOP : scnt++; at scnt==15: rx_s==1 -> commit byte, go IDLE;
//           rx_s==0 -> frame_err pulse, byte dropped, go BREAK.
//    BREAK: wait (any cycle) for rx_s==1 -> IDLE; no new start detected while low.
//  - Commit (same edge as FSM leaves STOP):
//    rec==00 -> rx_data1=shift, rec=01;
//    rec==01 -> rx_data2=shift, rec=11;
//    rec==11 -> data unchanged, overrun pulse.
//  - clr: rec<=00; rx_data1/rx_data2 keep their values.
//    clr coincident with commit: clear applies first, byte goes to rx_data1, rec=01, no overrun.
//  - rec never takes value 10.
//  - Pulses frame_err, overrun, parity_err are registered and last exactly one clk.
//  - Latency: the byte is visible the clk after the stop-bit sample tick, ~9.5 bit times after the start edge.
// CONFIGURATION
//  UART_PARITY_EN defined:
//    - Even-parity bit follows data; state PARITY after DATA.
//    - At scnt==15: record mismatch (rx_s != ^shift), scnt=0, then -> STOP.
//    - At STOP with good stop bit: a mismatch gives a parity_err pulse and drops the byte; rec unchanged.
//    - A bad stop bit takes priority: frame_err only.
//  UART_PARITY_EN undefined: no PARITY state; 8N1 only; parity_err=0 constant.
// TESTING (sim: CLK_FREQ=1_600_000, BAUD=10_000 -> DIV=10, 160 clk/bit)
//  1. Send 0x55 then 0xA3 -> rx_data1=0x55, rec=01 after first; rx_data2=0xA3, rec=11 after second.
//  2. rec=11, send 0x0F -> overrun high exactly 1 clk; rx_data1/2 unchanged; rec=11.
//  3. rx low 30 clks then high -> START aborts at sample, FSM IDLE, rec unchanged, no pulses.
//  4. Send 0x3C with stop bit low, line then held low 400 clks, then high;
//     send 0x3C normally -> frame_err 1 clk, byte dropped; second 0x3C stored, rec=01.
//  5. rec=11, clr asserted on the commit edge of 0x81 -> rec=01, rx_data1=0x81, overrun=0.
//  6. reset 1 clk at mid data bit 4 -> next clk outputs all 0, FSM IDLE;
//     then 0x12 -> rx_data1=0x12, rec=01.
//     Repeat case 1 with UART_PARITY_EN, then corrupt parity of 0x07 -> parity_err pulse, rec unchanged.

Source files
------------

// File: rtl/uart_rx_pair.sv
// uart_rx_pair: 8N1 UART receiver with 16x oversampling.
// Received bytes go into a two-entry holding buffer (rx_data1, rx_data2, rec).
// A clr pulse from the CPU empties the buffer.
// Optional feature macro: UART_PARITY_EN.
// When it is defined, the receiver expects an even-parity bit after the data bits.
// In that build a parity error drops the byte and pulses parity_err.
module uart_rx_pair #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       clr,
  output logic [7:0] rx_data1,
  output logic [7:0] rx_data2,
  output logic [1:0] rec,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  // Clocks per oversample tick; integer truncation is intentional.
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Input synchronizer. Both stages reset to the idle (high) line level.
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // Tick generator
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;

  // Receiver FSM and datapath
  state_t     state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_done;   // a frame ended with a good stop bit this cycle
  logic       frame_err_q, frame_err_d;

`ifdef UART_PARITY_EN
  logic       par_bad_q, par_bad_d;
  logic       parity_err_q, parity_err_d;
`endif

  // Holding buffer
  logic [7:0] rx_data1_q, rx_data1_d;
  logic [7:0] rx_data2_q, rx_data2_d;
  logic [1:0] rec_q, rec_d;
  logic [1:0] rec_base;
  logic       commit;
  logic       overrun_q, overrun_d;

  // Synchronizer next values: the line shifts through two stages.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  // Free-running divider; tick marks the last count of each period.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, sample counters, shift register and end-of-frame events.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick && !rx_s_q) begin
          state_d = S_START;
          scnt_d  = 4'd0;
`ifdef UART_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          if (scnt_q == 4'd7) begin
            // Sample near the middle of the start bit.
            // If the line is high again, treat the low as a glitch.
            if (!rx_s_q) begin
              state_d = S_DATA;
              scnt_d  = 4'd0;
              bcnt_d  = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (scnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};   // LSB arrives first
            scnt_d  = 4'd0;
            if (bcnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (scnt_q == 4'd15) begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            par_bad_d = (rx_s_q != ^shift_q);
            scnt_d    = 4'd0;
            state_d   = S_STOP;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (scnt_q == 4'd15) begin
            scnt_d = 4'd0;
            if (rx_s_q) begin
              byte_done = 1'b1;
              state_d   = S_IDLE;
            end else begin
              // Bad stop bit. Drop the byte and wait for the line to return high.
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        // This check runs every clock, not only on ticks.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decide whether the finished byte is kept.
  // In the parity build a parity mismatch drops the byte.
  // A bad stop bit never reaches this point, so it takes priority.
  always_comb begin
`ifdef UART_PARITY_EN
    commit       = byte_done && !par_bad_q;
    parity_err_d = byte_done && par_bad_q;
`else
    commit       = byte_done;
`endif
  end

  // Buffer update.
  // The clr pulse is applied first, so a byte arriving on the same edge
  // lands in rx_data1.
  always_comb begin
    rec_base   = clr ? 2'b00 : rec_q;
    rec_d      = rec_base;
    rx_data1_d = rx_data1_q;
    rx_data2_d = rx_data2_q;
    overrun_d  = 1'b0;
    if (commit) begin
      case (rec_base)
        2'b00: begin
          rx_data1_d = shift_q;
          rec_d      = 2'b01;
        end
        2'b01: begin
          rx_data2_d = shift_q;
          rec_d      = 2'b11;
        end
        default: begin
          overrun_d = 1'b1;
        end
      endcase
    end
  end

  // Registers for the synchronizer, divider, datapath, buffer and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      div_cnt_q    <= '0;
      scnt_q       <= 4'd0;
      bcnt_q       <= 3'd0;
      shift_q      <= 8'd0;
      frame_err_q  <= 1'b0;
      rx_data1_q   <= 8'd0;
      rx_data2_q   <= 8'd0;
      rec_q        <= 2'b00;
      overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      div_cnt_q    <= div_cnt_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      rx_data1_q   <= rx_data1_d;
      rx_data2_q   <= rx_data2_d;
      rec_q        <= rec_d;
      overrun_q    <= overrun_d;
`ifdef UART_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data1  = rx_data1_q;
  assign rx_data2  = rx_data2_q;
  assign rec       = rec_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
